// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared types and defaults for the receive-FIFO packet sequencer.
// The enum gives the FSM a fixed 2-bit encoding.
package rx_ctrl_pkg;

  localparam int unsigned MaxPktDef = 64;
  localparam int unsigned CntWDef   = 7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StReady = 2'd2,
    StFlush = 2'd3
  } state_t;

endpackage

// File: rtl/rx_fifo_ctrl_if.sv
// Bundle of receiver, consumer and FIFO-side signals around the packet sequencer.
// The master modport is the sequencer; the slave modport is everything around it.
interface rx_fifo_ctrl_if
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
);

  // Receiver side
  logic             rx_start;
  logic             rx_byte_valid;
  logic [7:0]       rx_byte;
  logic             rx_eop;
  logic             rx_error;
  // Consumer side
  logic             rd_req;
  logic             rd_valid;
  logic [7:0]       rd_data;
  // FIFO side
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_r_data;
  logic             fifo_w_enable;
  logic [7:0]       fifo_w_data;
  logic             fifo_r_enable;
  // Status
  logic             rx_busy;
  logic             pkt_ready;
  logic [CNT_W-1:0] pkt_len;
  logic             rx_err;

  modport master (
    input  rx_start, rx_byte_valid, rx_byte, rx_eop, rx_error,
    input  rd_req, fifo_full, fifo_empty, fifo_r_data,
    output fifo_w_enable, fifo_w_data, fifo_r_enable,
    output rx_busy, pkt_ready, pkt_len, rd_valid, rd_data, rx_err
  );

  modport slave (
    output rx_start, rx_byte_valid, rx_byte, rx_eop, rx_error,
    output rd_req, fifo_full, fifo_empty, fifo_r_data,
    input  fifo_w_enable, fifo_w_data, fifo_r_enable,
    input  rx_busy, pkt_ready, pkt_len, rd_valid, rd_data, rx_err
  );

endinterface

// File: rtl/rx_fifo_ctrl.sv
// Packet-level sequencer for the 8-bit receive FIFO: admits one packet at a time,
// gates writes, paces consumer reads and flushes the FIFO on error or overflow.
module rx_fifo_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned MAX_PKT = MaxPktDef,
  parameter int unsigned CNT_W   = CntWDef
) (
  input  logic          clk,
  input  logic          n_rst,
  rx_fifo_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PKT);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] pkt_len_q;
  logic             rx_err_q;
  logic             rx_busy_q;
  logic             pkt_ready_q;

  logic start_ok;
  logic overflow;
  logic w_en;
  logic r_en;

  always_comb begin
    start_ok = (state_q == StIdle) && bus.rx_start && bus.fifo_empty;
    overflow = bus.rx_byte_valid && (bus.fifo_full || (count_q == MaxCnt));
    w_en     = 1'b0;
    r_en     = 1'b0;
    case (state_q)
      // A byte that coincides with end-of-packet or an error is dropped.
      StRecv:  w_en = bus.rx_byte_valid && !bus.fifo_full && (count_q < MaxCnt) &&
                      !bus.rx_eop && !bus.rx_error;
      StReady: r_en = bus.rd_req && !bus.fifo_empty;
      StFlush: r_en = !bus.fifo_empty;
      default: ;
    endcase
  end

  assign bus.fifo_w_enable = w_en;
  assign bus.fifo_w_data   = (state_q == StRecv) ? bus.rx_byte : 8'h00;
  assign bus.fifo_r_enable = r_en;
  assign bus.rd_valid      = (state_q == StReady) && r_en;
  assign bus.rd_data       = (state_q == StReady) ? bus.fifo_r_data : 8'h00;
  assign bus.rx_busy       = rx_busy_q;
  assign bus.pkt_ready     = pkt_ready_q;
  assign bus.pkt_len       = pkt_len_q;
  assign bus.rx_err        = rx_err_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pkt_len_q   <= '0;
      rx_err_q    <= 1'b0;
      rx_busy_q   <= 1'b0;
      pkt_ready_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q   <= StRecv;
            count_q   <= '0;
            rx_err_q  <= 1'b0;
            rx_busy_q <= 1'b1;
          end
        end

        // Priority: error, then end-of-packet, then overflow, then a normal byte.
        StRecv: begin
          if (bus.rx_error) begin
            state_q  <= StFlush;
            rx_err_q <= 1'b1;
          end else if (bus.rx_eop) begin
            rx_busy_q <= 1'b0;
            if (count_q != '0) begin
              state_q     <= StReady;
              pkt_len_q   <= count_q;
              pkt_ready_q <= 1'b1;
            end else begin
              state_q   <= StIdle;
              pkt_len_q <= '0;
            end
          end else if (overflow) begin
            state_q  <= StFlush;
            rx_err_q <= 1'b1;
          end else if (w_en) begin
            count_q <= count_q + OneCnt;
          end
        end

        StReady: begin
          if (r_en) begin
            count_q <= count_q - OneCnt;
            if (count_q == OneCnt) begin
              state_q     <= StIdle;
              pkt_ready_q <= 1'b0;
            end
          end
        end

        StFlush: begin
          if (bus.fifo_empty) begin
            state_q   <= StIdle;
            count_q   <= '0;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= StIdle;
          rx_busy_q   <= 1'b0;
          pkt_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
